// File: rtl/calc_cu_if.sv
// Keypad-event and display bus of the calculator control unit.
// The master drives key levels and the slave drives the BCD digits and status flags.
interface calc_cu_if;
  logic [3:0] num;
  logic       numPressed;
  logic [2:0] opt;
  logic       optPressed;
  logic       submit;
  logic [3:0] num1;
  logic [3:0] num2;
  logic [3:0] num3;
  logic [3:0] num4;
  logic       sign;
  logic       clcCo;
  logic       clcZero;
  logic       cmpSign;

  modport master (
    output num, numPressed, opt, optPressed, submit,
    input  num1, num2, num3, num4, sign, clcCo, clcZero, cmpSign
  );

  modport slave (
    input  num, numPressed, opt, optPressed, submit,
    output num1, num2, num3, num4, sign, clcCo, clcZero, cmpSign
  );
endinterface

// File: rtl/calc_cu.sv
// Control and arithmetic unit of a 4-digit signed decimal calculator:
// key edge detection, operand/operator entry, add/sub/mul and BCD display drive.
module calc_cu (
  input  logic      clk,
  input  logic      reset,
  calc_cu_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_ENTRY_A = 2'd0,
    ST_ENTRY_B = 2'd1,
    ST_RESULT  = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_MUL = 2'd3;

  // Double-dabble conversion of a value 0..9999 into four BCD digits.
  function automatic logic [15:0] bin2bcd(input logic [13:0] bin);
    logic [29:0] sh;
    sh = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        sh[14 + 4 * d +: 4] = (sh[14 + 4 * d +: 4] >= 4'd5) ?
                              (sh[14 + 4 * d +: 4] + 4'd3) : sh[14 + 4 * d +: 4];
      end
      sh = sh << 1;
    end
    return sh[29:14];
  endfunction

  state_t             state_r;
  state_t             state_nx_s;
  logic               num_prev_r;
  logic               opt_prev_r;
  logic               sub_prev_r;
  logic signed [14:0] a_r;
  logic [13:0]        e_r;
  logic [1:0]         op_r;
  logic               seen_r;
  logic [13:0]        res_mag_r;
  logic               res_neg_r;
  logic               co_r;
  logic               zero_r;
  logic               cmp_r;

  logic               sub_ev_s;
  logic               opt_raw_s;
  logic               opt_ev_s;
  logic               dig_ev_s;
  logic               opt_ok_s;
  logic               dig_ok_s;

  logic signed [31:0] a_ext_s;
  logic signed [31:0] e_ext_s;
  logic signed [31:0] r_s;
  logic               r_neg_s;
  logic [31:0]        abs_u_s;
  logic               co_s;
  logic [13:0]        mag_s;
  logic               cmp_s;
  logic signed [14:0] res_a_s;
  logic signed [14:0] stored_a_s;
  logic [13:0]        e_shift_s;

  logic               a_ld_s;
  logic signed [14:0] a_nx_s;
  logic               e_ld_s;
  logic [13:0]        e_nx_s;
  logic               op_ld_s;
  logic               seen_set_s;
  logic               seen_clr_s;
  logic               eval_s;
  logic               res_clr_s;

  logic [13:0]        disp_s;
  logic [15:0]        bcd_s;

  // A held key produces one event; higher-priority events swallow lower ones.
  assign sub_ev_s  = bus.submit & ~sub_prev_r;
  assign opt_raw_s = bus.optPressed & ~opt_prev_r;
  assign opt_ev_s  = opt_raw_s & ~sub_ev_s;
  assign dig_ev_s  = bus.numPressed & ~num_prev_r & ~sub_ev_s & ~opt_raw_s;
  assign opt_ok_s  = opt_ev_s & (bus.opt >= 3'd1) & (bus.opt <= 3'd3);
  assign dig_ok_s  = dig_ev_s & (bus.num <= 4'd9);

  assign a_ext_s = {{17{a_r[14]}}, a_r};
  assign e_ext_s = {18'd0, e_r};

  // Full-precision evaluation of A OP E.
  always_comb begin
    r_s = a_ext_s + e_ext_s;
    case (op_r)
      OP_ADD:  r_s = a_ext_s + e_ext_s;
      OP_SUB:  r_s = a_ext_s - e_ext_s;
      OP_MUL:  r_s = a_ext_s * e_ext_s;
      default: r_s = a_ext_s + e_ext_s;
    endcase
  end

  assign r_neg_s    = r_s[31];
  assign abs_u_s    = r_neg_s ? 32'(-r_s) : 32'(r_s);
  assign co_s       = abs_u_s > 32'd9999;
  assign mag_s      = 14'(abs_u_s % 32'd10000);
  assign cmp_s      = a_ext_s < e_ext_s;
  assign res_a_s    = r_neg_s ? (15'd0 - {1'b0, mag_s}) : {1'b0, mag_s};
  assign stored_a_s = res_neg_r ? (15'd0 - {1'b0, res_mag_r}) : {1'b0, res_mag_r};
  assign e_shift_s  = 14'((32'(e_r) * 32'd10 + 32'(bus.num)) % 32'd10000);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_ENTRY_A;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_ENTRY_A: begin
        if (opt_ok_s) state_nx_s = ST_ENTRY_B;
        else          state_nx_s = ST_ENTRY_A;
      end
      ST_ENTRY_B: begin
        if (sub_ev_s) state_nx_s = ST_RESULT;
        else          state_nx_s = ST_ENTRY_B;
      end
      ST_RESULT: begin
        if (opt_ok_s)      state_nx_s = ST_ENTRY_B;
        else if (dig_ok_s) state_nx_s = ST_ENTRY_A;
        else               state_nx_s = ST_RESULT;
      end
      default: state_nx_s = ST_ENTRY_A;
    endcase
  end

  // Datapath control strobes per state and event.
  always_comb begin
    a_ld_s     = 1'b0;
    a_nx_s     = a_r;
    e_ld_s     = 1'b0;
    e_nx_s     = e_r;
    op_ld_s    = 1'b0;
    seen_set_s = 1'b0;
    seen_clr_s = 1'b0;
    eval_s     = 1'b0;
    res_clr_s  = 1'b0;
    case (state_r)
      ST_ENTRY_A: begin
        if (opt_ok_s) begin
          a_ld_s     = 1'b1;
          a_nx_s     = {1'b0, e_r};
          op_ld_s    = 1'b1;
          e_ld_s     = 1'b1;
          e_nx_s     = 14'd0;
          seen_clr_s = 1'b1;
        end else if (dig_ok_s) begin
          e_ld_s     = 1'b1;
          e_nx_s     = e_shift_s;
          seen_set_s = 1'b1;
        end else begin
          e_ld_s     = 1'b0;
        end
      end
      ST_ENTRY_B: begin
        if (sub_ev_s) begin
          eval_s     = 1'b1;
        end else if (opt_ok_s) begin
          // Chained operator only evaluates once a second operand exists.
          eval_s     = seen_r;
          a_ld_s     = seen_r;
          a_nx_s     = res_a_s;
          op_ld_s    = 1'b1;
          e_ld_s     = 1'b1;
          e_nx_s     = 14'd0;
          seen_clr_s = 1'b1;
        end else if (dig_ok_s) begin
          e_ld_s     = 1'b1;
          e_nx_s     = e_shift_s;
          seen_set_s = 1'b1;
        end else begin
          e_ld_s     = 1'b0;
        end
      end
      ST_RESULT: begin
        if (opt_ok_s) begin
          a_ld_s     = 1'b1;
          a_nx_s     = stored_a_s;
          op_ld_s    = 1'b1;
          e_ld_s     = 1'b1;
          e_nx_s     = 14'd0;
          seen_clr_s = 1'b1;
        end else if (dig_ok_s) begin
          res_clr_s  = 1'b1;
          e_ld_s     = 1'b1;
          e_nx_s     = {10'd0, bus.num};
          seen_set_s = 1'b1;
        end else begin
          e_ld_s     = 1'b0;
        end
      end
      default: begin
        e_ld_s = 1'b0;
      end
    endcase
  end

  // Key samples reset high so a key held across reset needs a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_prev_r <= 1'b1;
      opt_prev_r <= 1'b1;
      sub_prev_r <= 1'b1;
    end else begin
      num_prev_r <= bus.numPressed;
      opt_prev_r <= bus.optPressed;
      sub_prev_r <= bus.submit;
    end
  end

  // Operand, entry and operator registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r    <= 15'sd0;
      e_r    <= 14'd0;
      op_r   <= OP_ADD;
      seen_r <= 1'b0;
    end else begin
      if (a_ld_s)          a_r    <= a_nx_s;
      if (e_ld_s)          e_r    <= e_nx_s;
      if (op_ld_s)         op_r   <= bus.opt[1:0];
      if (seen_set_s)      seen_r <= 1'b1;
      else if (seen_clr_s) seen_r <= 1'b0;
    end
  end

  // Stored result and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_mag_r <= 14'd0;
      res_neg_r <= 1'b0;
      co_r      <= 1'b0;
      zero_r    <= 1'b0;
      cmp_r     <= 1'b0;
    end else if (eval_s) begin
      res_mag_r <= mag_s;
      res_neg_r <= r_neg_s;
      co_r      <= co_s;
      zero_r    <= (mag_s == 14'd0);
      cmp_r     <= cmp_s;
    end else if (res_clr_s) begin
      res_mag_r <= 14'd0;
      res_neg_r <= 1'b0;
      co_r      <= 1'b0;
      zero_r    <= 1'b0;
      cmp_r     <= 1'b0;
    end
  end

  assign disp_s      = (state_r == ST_RESULT) ? res_mag_r : e_r;
  assign bcd_s       = bin2bcd(disp_s);
  assign bus.num1    = bcd_s[15:12];
  assign bus.num2    = bcd_s[11:8];
  assign bus.num3    = bcd_s[7:4];
  assign bus.num4    = bcd_s[3:0];
  assign bus.sign    = (state_r == ST_RESULT) & res_neg_r & (res_mag_r != 14'd0);
  assign bus.clcCo   = co_r;
  assign bus.clcZero = zero_r;
  assign bus.cmpSign = cmp_r;

endmodule

// File: tb/tb_calc_cu.sv
// Directed bench for calc_cu: hand-computed display digits and flags
// after each key sequence, including priority, invalid keys and async reset.
module tb_calc_cu;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  calc_cu_if bus_if ();

  calc_cu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // exp_flags = {sign, clcCo, clcZero, cmpSign}
  task automatic check_out(input string tag, input logic [15:0] exp_disp, input logic [3:0] exp_flags);
    check({tag, "_disp"}, {bus_if.num1, bus_if.num2, bus_if.num3, bus_if.num4}, exp_disp);
    check({tag, "_flags"}, {12'd0, bus_if.sign, bus_if.clcCo, bus_if.clcZero, bus_if.cmpSign},
          {12'd0, exp_flags});
  endtask

  task automatic press_num(input logic [3:0] n);
    bus_if.num = n;
    bus_if.numPressed = 1'b1;
    tick();
    tick();
    bus_if.numPressed = 1'b0;
    tick();
  endtask

  task automatic press_opt(input logic [2:0] o);
    bus_if.opt = o;
    bus_if.optPressed = 1'b1;
    tick();
    tick();
    bus_if.optPressed = 1'b0;
    tick();
  endtask

  task automatic press_sub();
    bus_if.submit = 1'b1;
    tick();
    tick();
    bus_if.submit = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus_if.num        = 4'd0;
    bus_if.numPressed = 1'b0;
    bus_if.opt        = 3'd0;
    bus_if.optPressed = 1'b0;
    bus_if.submit     = 1'b0;
    reset = 1'b0;
    tick();
    check_out("reset", 16'h0000, 4'b0000);
    reset = 1'b1;
    tick();

    // 34 + 3 = 37
    press_num(4'd3);
    press_num(4'd4);
    check_out("entry34", 16'h0034, 4'b0000);
    press_opt(3'd1);
    check_out("after_add", 16'h0000, 4'b0000);
    press_num(4'd3);
    check_out("entryB3", 16'h0003, 4'b0000);
    press_sub();
    check_out("sum37", 16'h0037, 4'b0000);

    // 37 - 1234 = -1197
    press_opt(3'd2);
    press_num(4'd1);
    press_num(4'd2);
    press_num(4'd3);
    press_num(4'd4);
    check_out("entry1234", 16'h1234, 4'b0000);
    press_sub();
    check_out("diff_neg", 16'h1197, 4'b1001);

    // 9999 * 2 = 19998 -> overflow
    press_num(4'd9);
    check_out("new_entry9", 16'h0009, 4'b0000);
    press_num(4'd9);
    press_num(4'd9);
    press_num(4'd9);
    check_out("entry9999", 16'h9999, 4'b0000);
    press_opt(3'd3);
    press_num(4'd2);
    press_sub();
    check_out("mul_ovf", 16'h9998, 4'b0100);

    // 5 - 5 = 0, then new entry clears flags
    press_num(4'd5);
    press_opt(3'd2);
    press_num(4'd5);
    press_sub();
    check_out("zero", 16'h0000, 4'b0010);
    press_num(4'd7);
    check_out("digit_clears", 16'h0007, 4'b0000);

    // Shift past four digits; invalid keys; long hold
    press_num(4'd1);
    press_num(4'd2);
    press_num(4'd3);
    press_num(4'd4);
    press_num(4'd5);
    check_out("shift5", 16'h2345, 4'b0000);
    press_num(4'd12);
    check_out("bad_digit", 16'h2345, 4'b0000);
    press_opt(3'd5);
    check_out("bad_opt", 16'h2345, 4'b0000);
    press_sub();
    check_out("sub_in_A", 16'h2345, 4'b0000);
    bus_if.num = 4'd6;
    bus_if.numPressed = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus_if.numPressed = 1'b0;
    tick();
    check_out("long_hold", 16'h3456, 4'b0000);

    // submit beats digit: 3456 + 2 = 3458
    press_opt(3'd1);
    press_num(4'd2);
    bus_if.num = 4'd9;
    bus_if.numPressed = 1'b1;
    bus_if.submit = 1'b1;
    tick();
    tick();
    bus_if.numPressed = 1'b0;
    bus_if.submit = 1'b0;
    tick();
    check_out("prio_sub", 16'h3458, 4'b0000);

    // operator beats digit from RESULT
    bus_if.num = 4'd5;
    bus_if.numPressed = 1'b1;
    bus_if.opt = 3'd2;
    bus_if.optPressed = 1'b1;
    tick();
    tick();
    bus_if.numPressed = 1'b0;
    bus_if.optPressed = 1'b0;
    tick();
    check_out("prio_opt", 16'h0000, 4'b0000);

    // chained: 3458 - 9999 = -6541, then * 2 = -13082
    press_num(4'd9);
    press_num(4'd9);
    press_num(4'd9);
    press_num(4'd9);
    press_opt(3'd3);
    check_out("chain_eval", 16'h0000, 4'b0001);
    press_num(4'd2);
    press_sub();
    check_out("neg_mul_ovf", 16'h3082, 4'b1101);

    // operator replaced with no digit: -3082 - 1 = -3083
    press_opt(3'd1);
    press_opt(3'd2);
    press_num(4'd1);
    press_sub();
    check_out("op_replace", 16'h3083, 4'b1001);

    // async reset mid-ENTRY_B
    press_opt(3'd1);
    press_num(4'd4);
    check_out("pre_reset", 16'h0004, 4'b0001);
    #3;
    reset = 1'b0;
    #1;
    check_out("async_reset", 16'h0000, 4'b0000);
    bus_if.num = 4'd7;
    bus_if.numPressed = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    tick();
    check_out("held_through_reset", 16'h0000, 4'b0000);
    bus_if.numPressed = 1'b0;
    tick();
    press_sub();
    check_out("sub_after_reset", 16'h0000, 4'b0000);
    press_num(4'd5);
    press_opt(3'd1);
    press_num(4'd5);
    press_sub();
    check_out("post_reset_add", 16'h0010, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
